// File: rtl/clk_phase_div.sv
// Programmable clock divider with two non-overlapping phase enables and dead time.
// A new divide ratio is shadowed and applied only at a terminal count, so no half-period is cut short.
module clk_phase_div #(
   parameter int WIDTH   = 8,
   parameter int DIV_RST = 4,
   parameter int DEAD    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] div_in,
   output logic             clk_out,
   output logic             tick,
   output logic             ph1_en,
   output logic             ph2_en,
   output logic             pending
);

   localparam logic [WIDTH-1:0] DIV_RST_W = WIDTH'(DIV_RST);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_act;
   logic [WIDTH-1:0] div_shd;

   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] div_act_nxt;
   logic [WIDTH-1:0] div_shd_nxt;
   logic             clk_out_nxt;
   logic             pending_nxt;
   logic             tc;
   logic             past_dead;

   // div_act only changes on a terminal count, when cnt restarts at zero,
   // so cnt can never end up above the active ratio.
   always_comb begin
      tc          = en && (cnt == div_act);
      cnt_nxt     = cnt;
      clk_out_nxt = clk_out;
      div_act_nxt = div_act;
      div_shd_nxt = div_shd;
      pending_nxt = pending;

      if (en) begin
         if (tc) begin
            cnt_nxt     = '0;
            clk_out_nxt = ~clk_out;
         end else begin
            cnt_nxt = cnt + WIDTH'(1);
         end
      end

      if (load && tc) begin
         div_act_nxt = div_in;
         div_shd_nxt = div_in;
         pending_nxt = 1'b0;
      end else if (load) begin
         div_shd_nxt = div_in;
         pending_nxt = 1'b1;
      end else if (tc && pending) begin
         div_act_nxt = div_shd;
         pending_nxt = 1'b0;
      end

      past_dead = (64'(cnt_nxt) >= 64'(DEAD));
   end

   // Phase enables are derived from next-state values so they line up with clk_out edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         div_act <= DIV_RST_W;
         div_shd <= DIV_RST_W;
         pending <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         ph1_en  <= 1'b0;
         ph2_en  <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         div_act <= div_act_nxt;
         div_shd <= div_shd_nxt;
         pending <= pending_nxt;
         clk_out <= clk_out_nxt;
         tick    <= tc;
         ph1_en  <= clk_out_nxt & past_dead & en;
         ph2_en  <= ~clk_out_nxt & past_dead & en;
      end
   end

endmodule

// File: tb/tb_clk_phase_div.sv
// Directed bench for clk_phase_div (defaults WIDTH=8, DIV_RST=4, DEAD=1).
// Each step drives one cycle of inputs and checks every output after the edge.
module tb_clk_phase_div;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [7:0] div_in;
   logic       clk_out;
   logic       tick;
   logic       ph1_en;
   logic       ph2_en;
   logic       pending;

   int assertCount;
   int failCount;

   clk_phase_div dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .div_in  (div_in),
      .clk_out (clk_out),
      .tick    (tick),
      .ph1_en  (ph1_en),
      .ph2_en  (ph2_en),
      .pending (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Apply one cycle of inputs, clock it, then check all outputs 1 time unit after the edge.
   task automatic applyStimulus(input string tag, input logic r, input logic e, input logic l,
                                input logic [7:0] d, input logic expClk, input logic expTick,
                                input logic expPh1, input logic expPh2, input logic expPend);
      rst    = r;
      en     = e;
      load   = l;
      div_in = d;
      @(posedge clk);
      #1;
      checkOutput({tag, ".clk_out"}, 32'(clk_out), 32'(expClk));
      checkOutput({tag, ".tick"},    32'(tick),    32'(expTick));
      checkOutput({tag, ".ph1_en"},  32'(ph1_en),  32'(expPh1));
      checkOutput({tag, ".ph2_en"},  32'(ph2_en),  32'(expPh2));
      checkOutput({tag, ".pending"}, 32'(pending), 32'(expPend));
      checkOutput({tag, ".excl"},    32'(ph1_en & ph2_en), 32'(0));
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst    = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      div_in = 8'd0;

      //              tag      rst en ld div   clk tk p1 p2 pd
      applyStimulus("rst0",   1, 0, 0, 8'd0,  0, 0, 0, 0, 0);
      applyStimulus("rst1",   1, 1, 0, 8'd0,  0, 0, 0, 0, 0);

      // Default ratio 4: half-period 5, ph1/ph2 high 4 of 5
      applyStimulus("d01",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("d02",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("d03",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("d04",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("d05tc",  0, 1, 0, 8'd0,  1, 1, 0, 0, 0);
      applyStimulus("d06",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);
      applyStimulus("d07",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);
      applyStimulus("d08",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);
      applyStimulus("d09",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);
      applyStimulus("d10tc",  0, 1, 0, 8'd0,  0, 1, 0, 0, 0);

      // Load 2 at cnt=1: current half-period keeps 5 cycles, then 3-cycle halves
      applyStimulus("s11",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("s12ld",  0, 1, 1, 8'd2,  0, 0, 0, 1, 1);
      applyStimulus("s13",    0, 1, 0, 8'd0,  0, 0, 0, 1, 1);
      applyStimulus("s14",    0, 1, 0, 8'd0,  0, 0, 0, 1, 1);
      applyStimulus("s15tc",  0, 1, 0, 8'd0,  1, 1, 0, 0, 0);
      applyStimulus("s16",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);
      applyStimulus("s17",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);
      applyStimulus("s18tc",  0, 1, 0, 8'd0,  0, 1, 0, 0, 0);
      applyStimulus("s19",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("s20",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("s21tc",  0, 1, 0, 8'd0,  1, 1, 0, 0, 0);

      // Load 0 coincident with TC: direct update, then toggle every cycle with tick held high
      applyStimulus("z22",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);
      applyStimulus("z23",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);
      applyStimulus("z24ld",  0, 1, 1, 8'd0,  0, 1, 0, 0, 0);
      applyStimulus("z25",    0, 1, 0, 8'd0,  1, 1, 0, 0, 0);
      applyStimulus("z26",    0, 1, 0, 8'd0,  0, 1, 0, 0, 0);
      applyStimulus("z27",    0, 1, 0, 8'd0,  1, 1, 0, 0, 0);

      // Load while disabled goes to the shadow; en gap mid-half-period freezes state
      applyStimulus("g28ld",  0, 0, 1, 8'd4,  1, 0, 0, 0, 1);
      applyStimulus("g29tc",  0, 1, 0, 8'd0,  0, 1, 0, 0, 0);
      applyStimulus("g30",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("g31",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("g32off", 0, 0, 0, 8'd0,  0, 0, 0, 0, 0);
      applyStimulus("g33off", 0, 0, 0, 8'd0,  0, 0, 0, 0, 0);
      applyStimulus("g34off", 0, 0, 0, 8'd0,  0, 0, 0, 0, 0);
      applyStimulus("g35",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("g36",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("g37tc",  0, 1, 0, 8'd0,  1, 1, 0, 0, 0);

      // Load 7, reset at cnt=3 with load asserted: ratio returns to 4
      applyStimulus("r38ld",  0, 1, 1, 8'd7,  1, 0, 1, 0, 1);
      applyStimulus("r39",    0, 1, 0, 8'd0,  1, 0, 1, 0, 1);
      applyStimulus("r40",    0, 1, 0, 8'd0,  1, 0, 1, 0, 1);
      applyStimulus("r41rst", 1, 1, 1, 8'd9,  0, 0, 0, 0, 0);
      applyStimulus("r42",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("r43",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("r44",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("r45",    0, 1, 0, 8'd0,  0, 0, 0, 1, 0);
      applyStimulus("r46tc",  0, 1, 0, 8'd0,  1, 1, 0, 0, 0);
      applyStimulus("r47",    0, 1, 0, 8'd0,  1, 0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/clk_phase_div.md
CLK_PHASE_DIV -- requirements
Module: clk_phase_div

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the width of the divide-ratio counter and ports.
REQ-002 The module SHALL have parameter DIV_RST, default 4, the divide ratio loaded at reset.
REQ-003 The module SHALL have parameter DEAD, default 1, the number of dead-time cycles after each clk_out toggle during which both phase enables are low.
REQ-004 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; while low, all state holds and tick, ph1_en and ph2_en are 0.
REQ-007 load  input  1  one-cycle strobe that captures div_in as the new divide ratio.
REQ-008 div_in  input  WIDTH  new divide ratio N; the half-period is N+1 cycles.
REQ-009 clk_out  output  1  divided clock, 50% duty, period 2*(N+1) cycles, registered.
REQ-010 tick  output  1  one-cycle pulse on every clk_out toggle, registered.
REQ-011 ph1_en  output  1  phase-1 enable: high while clk_out=1 and outside dead time, registered.
REQ-012 ph2_en  output  1  phase-2 enable: high while clk_out=0 and outside dead time, registered.
REQ-013 pending  output  1  high while a loaded ratio waits for the next terminal count.

Function
REQ-014 Internal state SHALL be cnt[WIDTH-1:0], div_act[WIDTH-1:0], div_shd[WIDTH-1:0], the pending flag, and clk_out.
REQ-015 Terminal count (TC) SHALL be the condition en=1 and cnt==div_act.
REQ-016 On TC the block SHALL set cnt<=0, toggle clk_out and set tick<=1.
REQ-017 On an enabled cycle that is not TC, the block SHALL set cnt<=cnt+1 and tick<=0.
REQ-018 When en=0, cnt and clk_out SHALL hold; tick, ph1_en and ph2_en SHALL be 0 on the next cycle.
REQ-019 load=1 without TC SHALL set div_shd<=div_in and pending<=1; a later load SHALL overwrite div_shd.
REQ-020 On TC with pending=1, the block SHALL set div_act<=div_shd and clear pending, so that no half-period is truncated or stretched.
REQ-021 load=1 coincident with TC SHALL set div_act<=div_in directly and clear pending, taking effect from the next half-period.
REQ-022 load is accepted regardless of en.
REQ-023 N=0 SHALL make clk_out toggle and tick assert on every enabled cycle.
REQ-024 ph1_en SHALL be registered from next-state values as next_clk_out & (next_cnt >= DEAD) & en, so it is edge-aligned with clk_out.
REQ-025 ph2_en SHALL be registered from next-state values as ~next_clk_out & (next_cnt >= DEAD) & en.
REQ-026 ph1_en and ph2_en SHALL never be high in the same cycle.
REQ-027 If DEAD > div_act, the corresponding phase enable SHALL stay 0 for that half-period.
REQ-028 cnt SHALL never exceed div_act, including when div_act changes.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set cnt=0, clk_out=0, tick=0, ph1_en=0, ph2_en=0, pending=0, div_act=DIV_RST and div_shd=DIV_RST.
REQ-030 rst SHALL take priority over en and load.
REQ-031 Reset asserted mid-period SHALL abort the period; the first TC after release SHALL occur DIV_RST+1 enabled cycles after release.

Verification
REQ-032 Reset then en=1 with defaults (N=4, DEAD=1): clk_out period 10 cycles, tick every 5 cycles, ph1_en high 4 of the 5 clk_out-high cycles.
REQ-033 load with div_in=2 at cnt=1: pending=1 until the next TC; the current half-period stays 5 cycles, then half-periods of 3 cycles follow.
REQ-034 load with div_in=0 coincident with TC: the next half-period is 1 cycle, and tick stays high continuously while en=1.
REQ-035 en dropped for 3 cycles mid-half-period: cnt and clk_out frozen, phase enables 0, and the half-period resumes and completes with the correct total of enabled cycles.
REQ-036 N=0 with DEAD=1: ph1_en and ph2_en stay 0 throughout, and clk_out toggles every cycle.
REQ-037 rst pulsed at cnt=3 with N=7 loaded: all outputs 0, div_act=4, and the first tick 5 cycles after release.
